sram_ctrl: RTL



---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM controller, its SRAM model and bench.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RESP  = 3'd3,
    CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port SRAM initiator: writes take 1 pin cycle, reads respond 2 cycles after accept,
// responses are held until rsp_ready; clear walks all addresses; req_ready is low whenever busy.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = SRAM_ADDR_W,
  parameter int                DATA_W    = SRAM_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clear_start,
  output logic              clear_done,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic              accept;
  logic              clr_go;
  logic              clr_last;

  assign clr_last = (state == CLEAR) && (cnt == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_d;
  end

  // clear_start has priority over a request presented in the same IDLE cycle
  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    clr_go    = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          clr_go  = 1'b1;
          state_d = CLEAR;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            accept  = 1'b1;
            state_d = req_write ? WRITE : READ;
          end
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      CLEAR:   if (clr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      addr_q  <= '0;
      cnt     <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= clr_last;
      if (clr_go) begin
        cnt     <= '0;
        wdata_q <= CLEAR_VAL;
      end else if (accept) begin
        addr_q <= req_addr;
        // write data pin only changes for writes so it holds while we is low
        if (req_write) wdata_q <= req_wdata;
      end
      if (state == CLEAR) begin
        addr_q <= cnt;
        cnt    <= cnt + 1'b1;
      end
      if (state == READ) rdata_q <= sram_rdata;
    end
  end

  assign sram_addr  = (state == CLEAR) ? cnt : addr_q;
  assign sram_wdata = wdata_q;
  assign sram_we    = (state == WRITE) || (state == CLEAR);
  assign sram_oe    = (state == READ);
  assign rsp_valid  = (state == RESP);
  assign rsp_rdata  = rdata_q;
  assign clear_done = done_q;
  assign busy       = (state != IDLE);

endmodule
